// File: rtl/mult_result_accumulator.sv
// Accumulator stage behind the 27x18 / SIMD 9x9 decomposed multiplier.
// Finishes the pre-add of the two partial-sum words, then accumulates products
// as one wide value (mode 0) or two independent lanes (mode 1). Each lane has
// saturating or wrapping overflow handling. Finished results go out over a
// valid/ready handshake.
// Width constraint: mode 0 needs ACC_W >= 45, and mode 1 needs LANE_W >= 29.
// Lane 0 values are 29 bits wide.
module mult_result_accumulator #(
  parameter int ACC_W    = 64,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [44:0]      result_0,
  input  logic [44:0]      result_1,
  input  logic [3:0]       result_SIMD_carry,
  input  logic             mode,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [1:0]       ovf,
  output logic             mode_err
);

  localparam int LANE_W = ACC_W / 2;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               mode_err_q, mode_err_d;
  logic               mode_l_q, mode_l_d;
  logic               sign_l_q, sign_l_d;

  logic               accept;
  logic               eff_mode, eff_sign;
  logic [ACC_W-1:0]   acc_base;

  // An IDLE beat opens a new accumulation and uses its own mode/sign.
  // Later beats always use the values latched at open time.
  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign eff_mode = (state_q == IDLE) ? mode    : mode_l_q;
  assign eff_sign = (state_q == IDLE) ? in_sign : sign_l_q;
  // Loading in IDLE is an add onto zero, so that path can never overflow.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

  // Pre-add of the partial-sum words. The lane split drops the carry at bit 27.
  logic [44:0] sum_wide;
  logic [26:0] sum_lo;
  logic [17:0] sum_hi;
  logic [28:0] lane0_val;
  logic [19:0] lane1_val;

  assign sum_wide  = result_0 + result_1;
  assign sum_lo    = result_0[26:0] + result_1[26:0];
  assign sum_hi    = result_0[44:27] + result_1[44:27];
  assign lane0_val = {result_SIMD_carry[1:0], sum_lo};
  assign lane1_val = {result_SIMD_carry[3:2], sum_hi};

  // Wide (27x18) accumulation. One extra sum bit carries the overflow information.
  logic [ACC_W-1:0] beat_wide, wide_sat, wide_res;
  logic [ACC_W:0]   wide_sum;
  logic             wide_ovf;

  assign beat_wide = eff_sign ? ACC_W'($signed(sum_wide)) : ACC_W'(sum_wide);
  assign wide_sum  = {eff_sign & acc_base[ACC_W-1], acc_base}
                   + {eff_sign & beat_wide[ACC_W-1], beat_wide};
  assign wide_ovf  = eff_sign ? (wide_sum[ACC_W] ^ wide_sum[ACC_W-1]) : wide_sum[ACC_W];
  assign wide_sat  = !eff_sign     ? {ACC_W{1'b1}} :
                     wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                       {1'b0, {(ACC_W-1){1'b1}}};
  assign wide_res  = (SATURATE && wide_ovf) ? wide_sat : wide_sum[ACC_W-1:0];

  // SIMD lanes. Each lane is a fully independent adder with its own clamp.
  logic [LANE_W-1:0] lane_acc  [2];
  logic [LANE_W-1:0] lane_beat [2];
  logic [LANE_W-1:0] lane_res  [2];
  logic [1:0]        lane_ovf;

  assign lane_acc[0]  = acc_base[LANE_W-1:0];
  assign lane_acc[1]  = acc_base[ACC_W-1:LANE_W];
  assign lane_beat[0] = eff_sign ? LANE_W'($signed(lane0_val)) : LANE_W'(lane0_val);
  assign lane_beat[1] = eff_sign ? LANE_W'($signed(lane1_val)) : LANE_W'(lane1_val);

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [LANE_W:0]   lsum;
    logic [LANE_W-1:0] lsat;
    assign lsum = {eff_sign & lane_acc[gi][LANE_W-1], lane_acc[gi]}
                + {eff_sign & lane_beat[gi][LANE_W-1], lane_beat[gi]};
    assign lane_ovf[gi] = eff_sign ? (lsum[LANE_W] ^ lsum[LANE_W-1]) : lsum[LANE_W];
    assign lsat = !eff_sign    ? {LANE_W{1'b1}} :
                  lsum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} :
                                 {1'b0, {(LANE_W-1){1'b1}}};
    assign lane_res[gi] = (SATURATE && lane_ovf[gi]) ? lsat : lsum[LANE_W-1:0];
  end

  // Next-state logic and datapath updates for the IDLE/ACC/DONE controller.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    ovf_d      = ovf_q;
    mode_err_d = mode_err_q;
    mode_l_d   = mode_l_q;
    sign_l_d   = sign_l_q;
    if (accept) begin
      acc_d = eff_mode ? {lane_res[1], lane_res[0]} : wide_res;
      if (state_q == IDLE) begin
        mode_l_d   = mode;
        sign_l_d   = in_sign;
        ovf_d      = 2'b00;
        mode_err_d = 1'b0;
      end else begin
        ovf_d = ovf_q | (eff_mode ? lane_ovf : {1'b0, wide_ovf});
        if ((mode != mode_l_q) || (in_sign != sign_l_q)) begin
          mode_err_d = 1'b1;
        end
      end
      if (in_last) begin
        state_d   = DONE;
        acc_out_d = acc_d;
      end else begin
        state_d = ACC;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
  end

  // State and data registers. Reset discards any open or pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_out_q  <= '0;
      ovf_q      <= 2'b00;
      mode_err_q <= 1'b0;
      mode_l_q   <= 1'b0;
      sign_l_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
      ovf_q      <= ovf_d;
      mode_err_q <= mode_err_d;
      mode_l_q   <= mode_l_d;
      sign_l_q   <= sign_l_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;
  assign mode_err  = mode_err_q;

endmodule
